ecc_enc_sched: RTL
==================

# ecc_enc_sched

Two-requester scheduler that shares one Golay(24,12) `ecc_encode` instance in the PROM ECC path. It arbitrates round-robin between two 12-bit word sources and sequences each word through the registered encoder. Each encoded word is presented as a systematic 24-bit codeword with valid/ready backpressure toward the PROM write logic. It also keeps a saturating per-source count of words encoded.

## Interface
- CNT_W, 16, width of each per-source encoded-word counter
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- REQ0_VLD  in  1  source 0 has a word
- REQ0_DATA  in  12  source 0 word
- REQ0_RDY  out  1  source 0 word accepted this cycle (VLD&RDY = handshake)
- REQ1_VLD  in  1  source 1 has a word
- REQ1_DATA  in  12  source 1 word
- REQ1_RDY  out  1  source 1 word accepted this cycle
- CW_VLD  out  1  codeword valid
- CW  out  24  {PARITY[11:0], DATA[11:0]}
- CW_SRC  out  1  source index of CW
- CW_RDY  in  1  downstream accepts CW (CW_VLD&CW_RDY = transfer)
- CNT0  out  CNT_W  words from source 0 transferred out, saturating
- CNT1  out  CNT_W  words from source 1 transferred out, saturating

## Operation
- FSM states: IDLE, ENC, OUT.
- IDLE:
  - REQx_RDY is combinational and asserted only in IDLE, to the granted source only.
  - Grant goes to the single valid requester. If both are valid, grant goes to the source not served last (LAST pointer).
  - On handshake: DREG <= REQx_DATA, SRC <= x, LAST <= x, go to ENC.
- ENC: DREG drives the encoder DATA input. Encoder registers PARITY at the closing edge. Go to OUT unconditionally.
- OUT:
  - CW_VLD=1, CW={PARITY,DREG}, CW_SRC=SRC.
  - DREG and SRC are held, so CW is stable while stalled.
  - On CW_RDY: CNT[SRC] increments (saturates at all-ones), go to IDLE.
  - Without CW_RDY: stay in OUT indefinitely.
- No word is accepted outside IDLE, so there is at most one word in flight.
- A word is never dropped or duplicated except on reset.
- REQx_DATA matters only in the handshake cycle.
- Reset values: state=IDLE, DREG=0, SRC=0, LAST=1 (so source 0 wins the first tie), CNT0=CNT1=0, CW_VLD=0, REQ0_RDY=REQ1_RDY=0 during reset.
- CW and CW_SRC are don't-care while CW_VLD=0, but must be driven (no X) after reset.

## Timing
- Handshake in cycle t → CW_VLD high from cycle t+2.
- Minimum period is 3 cycles per word (IDLE, ENC, OUT with CW_RDY tied high).
- The transfer cycle returns the FSM to IDLE. The next handshake is possible in cycle t+3.
- CNT updates on the edge closing the transfer cycle and is visible the following cycle.
- RST asserted in any state: state returns to IDLE next edge, the in-flight word is discarded, and CW_VLD=0 the cycle after.
- RST has priority over CW_RDY in the same cycle: the counter is not incremented.
- Both VLD high in consecutive IDLE visits: grants alternate 0,1,0,1.
- A source deasserting VLD while the FSM is outside IDLE has no effect.
- CNT saturation: at 2^CNT_W−1 further transfers leave the count unchanged. No wrap to 0.

## Structure
- Shared package ecc_pkg:
  - FSM state encoding (IDLE/ENC/OUT).
  - CW_W=24 and DW=12.
  - The Golay parity-column constants BI1..BI12, so the bench model and future decoder use one copy.
- One sub-module: an `ecc_encode` instance (CLK, DATA←DREG, PARITY). No other hierarchy.
- Arbiter, FSM and counters live inline.

## Test plan
- Single word: after reset, REQ0 sends 0x001 with CW_RDY=1 → CW=0xB71001, CW_SRC=0, CW_VLD in cycle t+2, CNT0=1.
- Parity check: REQ1 sends 0x800 → CW=0x7FF800, CW_SRC=1. REQ1 sends 0x000 → CW=0x000000. Then compare random words against the package-constant reference model.
- Tie fairness: both VLD held high for 8 words → CW_SRC sequence 0,1,0,1,0,1,0,1. CNT0=CNT1=4.
- Backpressure: CW_RDY low for 10 cycles in OUT → CW/CW_SRC stable, both REQx_RDY=0, no count change. Raise CW_RDY → one transfer, then IDLE.
- Reset mid-flight: RST pulsed in ENC and, separately, in OUT with CW_RDY=1 → no CW transfer, counters 0, REQ0 wins the next tie.
- Saturation: CNT_W=3, 9 transfers from source 0 → CNT0 stops at 7. CNT1 unaffected.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the PROM ECC path.
// Holds the scheduler FSM encoding, the codeword and data widths, and the
// Golay(24,12) parity-column constants. The encoder and any checking model
// or future decoder all read these constants from this one place.
package ecc_pkg;

    localparam int DW   = 12;
    localparam int CW_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // BIk selects the data bits that feed parity bit k-1.
    // The B matrix is symmetric, so BIk is also the parity contribution of
    // data bit k-1 on its own.
    localparam logic [DW-1:0] BI1  = 12'hB71;
    localparam logic [DW-1:0] BI2  = 12'hDB8;
    localparam logic [DW-1:0] BI3  = 12'hADC;
    localparam logic [DW-1:0] BI4  = 12'h96E;
    localparam logic [DW-1:0] BI5  = 12'h8B7;
    localparam logic [DW-1:0] BI6  = 12'hC5B;
    localparam logic [DW-1:0] BI7  = 12'hE2D;
    localparam logic [DW-1:0] BI8  = 12'hF16;
    localparam logic [DW-1:0] BI9  = 12'hB8B;
    localparam logic [DW-1:0] BI10 = 12'hDC5;
    localparam logic [DW-1:0] BI11 = 12'hEE2;
    localparam logic [DW-1:0] BI12 = 12'h7FF;

    function automatic logic [DW-1:0] golay_parity(input logic [DW-1:0] d);
        logic [DW-1:0] p;
        p[0]  = ^(d & BI1);
        p[1]  = ^(d & BI2);
        p[2]  = ^(d & BI3);
        p[3]  = ^(d & BI4);
        p[4]  = ^(d & BI5);
        p[5]  = ^(d & BI6);
        p[6]  = ^(d & BI7);
        p[7]  = ^(d & BI8);
        p[8]  = ^(d & BI9);
        p[9]  = ^(d & BI10);
        p[10] = ^(d & BI11);
        p[11] = ^(d & BI12);
        return p;
    endfunction

endpackage

// File: rtl/ecc_encode.sv
// Registered Golay(24,12) parity generator.
// Ports:
//   CLK    - clock, rising edge
//   DATA   - 12-bit data word
//   PARITY - 12-bit parity of DATA, registered (one cycle latency)
module ecc_encode
    import ecc_pkg::*;
(
    input  logic          CLK,
    input  logic [DW-1:0] DATA,
    output logic [DW-1:0] PARITY
);

    // Parity is recomputed every cycle. The scheduler holds DATA steady from
    // ENC through OUT, so PARITY stays valid for the whole output phase.
    always_ff @(posedge CLK) begin
        PARITY <= golay_parity(DATA);
    end

endmodule

// File: rtl/ecc_enc_sched.sv
// Two-source scheduler in front of one shared Golay(24,12) encoder.
// Each word is taken through IDLE -> ENC -> OUT, so one word is in flight at
// most. Grants between sources are round-robin, and a saturating count of
// delivered words is kept per source.
// Ports:
//   CLK, RST             - clock and synchronous active-high reset
//   REQx_VLD/DATA/RDY    - source x word handshake (RDY only in IDLE)
//   CW_VLD/CW/CW_SRC     - codeword {PARITY, DATA} and its source index
//   CW_RDY               - downstream accept
//   CNT0/CNT1            - saturating count of codewords delivered per source
module ecc_enc_sched
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VLD,
    input  logic [DW-1:0]    REQ0_DATA,
    output logic             REQ0_RDY,
    input  logic             REQ1_VLD,
    input  logic [DW-1:0]    REQ1_DATA,
    output logic             REQ1_RDY,
    output logic             CW_VLD,
    output logic [CW_W-1:0]  CW,
    output logic             CW_SRC,
    input  logic             CW_RDY,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1
);

    state_t            r_state;
    state_t            w_next;
    logic [DW-1:0]     r_dreg;
    logic              r_src;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;
    logic [DW-1:0]     w_parity;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    ecc_encode u_enc (
        .CLK    (CLK),
        .DATA   (r_dreg),
        .PARITY (w_parity)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On a tie the source not served last wins; r_last=1 means
                // source 1 went last.
                if (REQ0_VLD && REQ1_VLD) begin
                    w_gnt0 = r_last;
                    w_gnt1 = !r_last;
                end else begin
                    w_gnt0 = REQ0_VLD;
                    w_gnt1 = REQ1_VLD;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_next = ST_ENC;
                end
            end
            ST_ENC: begin
                w_next = ST_OUT;
            end
            ST_OUT: begin
                if (CW_RDY) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Reset masks the handshake and output strobes so nothing is accepted
    // or delivered in a reset cycle.
    assign REQ0_RDY = w_gnt0 && !RST;
    assign REQ1_RDY = w_gnt1 && !RST;
    assign CW_VLD   = (r_state == ST_OUT) && !RST;
    assign w_xfer   = CW_VLD && CW_RDY;
    // Zero while idle so the bus never carries X before the first encode.
    assign CW       = CW_VLD ? {w_parity, r_dreg} : '0;
    assign CW_SRC   = r_src;
    assign CNT0     = r_cnt0;
    assign CNT1     = r_cnt1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dreg <= '0;
            r_src  <= 1'b0;
            r_last <= 1'b1;
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_dreg <= w_gnt1 ? REQ1_DATA : REQ0_DATA;
                r_src  <= w_gnt1;
                r_last <= w_gnt1;
            end
            if (w_xfer) begin
                if (r_src) begin
                    r_cnt1 <= sat_inc(r_cnt1);
                end else begin
                    r_cnt0 <= sat_inc(r_cnt0);
                end
            end
        end
    end

endmodule
